// File: rtl/mmu_pkg.sv
// Shared definitions for the paged MMU: control register offsets within the
// register block, the fixed RTI-trigger read value and the task-state encoding.
package mmu_pkg;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_AKEY  = 3'd1;
  localparam logic [2:0] REG_TKEY  = 3'd2;
  localparam logic [2:0] REG_RTI   = 3'd3;
  localparam logic [2:0] REG_FTASK = 3'd4;
  localparam logic [2:0] REG_FPAGE = 3'd5;
  localparam logic [7:0] REG_COUNT = 8'd6;

  localparam logic [7:0] RTI_READ_VAL = 8'h3B;

  typedef enum logic [1:0] {
    ST_SUPER = 2'b00,
    ST_PEND  = 2'b01,
    ST_USER  = 2'b10
  } mmu_state_t;

endpackage

// File: rtl/mmu_task_fsm.sv
// Supervisor/user task sequencer.
//   E          falling edge updates state
//   nRESET     asynchronous active-low reset
//   vec_fetch  vector fetch this cycle (forces supervisor, cancels pending)
//   rti_read   read of the RTI-trigger register this cycle
//   super_mode 1 unless the user task is active
//   pend       switch to user task pending
//   user_mode  user task active
//   task_sel   translate with task_key (user task, not a vector fetch)
module mmu_task_fsm
  import mmu_pkg::*;
#(
  parameter int unsigned RTI_DELAY = 2
) (
  input  logic E,
  input  logic nRESET,
  input  logic vec_fetch,
  input  logic rti_read,
  output logic super_mode,
  output logic pend,
  output logic user_mode,
  output logic task_sel
);

  mmu_state_t state;
  logic [3:0] cnt;

  // The RTI-trigger edge itself counts as the first delay cycle, so the
  // user task is active after exactly RTI_DELAY falling edges.
  always_ff @(negedge E or negedge nRESET) begin
    if (!nRESET) begin
      state <= ST_SUPER;
      cnt   <= '0;
    end else if (vec_fetch) begin
      state <= ST_SUPER;
      cnt   <= '0;
    end else begin
      case (state)
        ST_SUPER: begin
          if (rti_read) begin
            if (RTI_DELAY <= 1) begin
              state <= ST_USER;
            end else begin
              state <= ST_PEND;
              cnt   <= 4'(RTI_DELAY - 1);
            end
          end
        end
        ST_PEND: begin
          if (cnt <= 4'd1) begin
            state <= ST_USER;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_USER: ;
        default: begin
          state <= ST_SUPER;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign super_mode = (state != ST_USER);
  assign pend       = (state == ST_PEND);
  assign user_mode  = (state == ST_USER);
  assign task_sel   = user_mode & ~vec_fetch;

endmodule

// File: rtl/mmu_task_switch.sv
// 6809 paged MMU with task-switch sequencer. Translates ADDR's top PAGE_BITS
// through an external mapping RAM addressed by {key, page}.
//   E, nRESET           E clock (falling edge active), async active-low reset
//   ADDR, RnW, BA, BS   CPU bus; !BA & BS & RnW marks a vector fetch
//   DATA                CPU data bus (driven on register/window reads)
//   MMU_ADDR            mapping RAM address {key, page}
//   MMU_nRD, MMU_nWR    mapping RAM output enable / write strobe
//   MMU_DATA            mapping RAM data (physical page)
//   SUPER               supervisor mapping in use
//   nWRPROT, nFAULT     write suppress / latched protection fault
// Optional feature: `define MMU_WPROT_EN enables MMU_DATA[7] write protection.
module mmu_task_switch
  import mmu_pkg::*;
#(
  parameter logic [15:0] IO_PAGE   = 16'hFE00,
  parameter logic [7:0]  REG_OFS   = 8'h10,
  parameter logic [7:0]  MAP_OFS   = 8'h20,
  parameter int unsigned PAGE_BITS = 3,
  parameter int unsigned TASK_BITS = 5,
  parameter int unsigned RTI_DELAY = 2
) (
  input  logic                           E,
  input  logic                           nRESET,
  input  logic [15:0]                    ADDR,
  input  logic                           RnW,
  input  logic                           BA,
  input  logic                           BS,
  inout  wire  [7:0]                     DATA,
  output logic [TASK_BITS+PAGE_BITS-1:0] MMU_ADDR,
  output logic                           MMU_nRD,
  output logic                           MMU_nWR,
  inout  wire  [7:0]                     MMU_DATA,
  output logic                           SUPER,
  output logic                           nWRPROT,
  output logic                           nFAULT
);

  logic                 io_hit, reg_hit, win_hit;
  logic [7:0]           reg_ofs, win_ofs;
  logic                 vec_fetch, rti_read, reg_wr;
  logic                 enmmu;
  logic [TASK_BITS-1:0] access_key, task_key, key;
  logic [PAGE_BITS-1:0] cpu_page, map_page;
  logic                 super_mode, pend, user_mode, task_sel;
  logic                 win_wr, win_rd;
  logic                 mmu_oe, map_wr_oe, data_oe;
  logic [7:0]           mmu_out, data_out, reg_rdata;
  logic                 fault;
  logic [7:0]           fault_task, fault_page;

  assign io_hit    = (ADDR[15:8] == IO_PAGE[15:8]);
  assign reg_ofs   = ADDR[7:0] - REG_OFS;
  assign win_ofs   = ADDR[7:0] - MAP_OFS;
  assign reg_hit   = io_hit & (reg_ofs < REG_COUNT);
  assign win_hit   = io_hit & (win_ofs < 8'(2 ** PAGE_BITS));
  assign vec_fetch = ~BA & BS & RnW;
  assign rti_read  = reg_hit & RnW & (reg_ofs[2:0] == REG_RTI);
  assign reg_wr    = reg_hit & ~RnW;
  assign cpu_page  = ADDR[15 -: PAGE_BITS];

  mmu_task_fsm #(
    .RTI_DELAY(RTI_DELAY)
  ) u_fsm (
    .E         (E),
    .nRESET    (nRESET),
    .vec_fetch (vec_fetch),
    .rti_read  (rti_read),
    .super_mode(super_mode),
    .pend      (pend),
    .user_mode (user_mode),
    .task_sel  (task_sel)
  );

  assign SUPER = super_mode;

  always_comb begin
    key      = '0;
    map_page = cpu_page;
    if (win_hit) begin
      key      = access_key;
      map_page = ADDR[PAGE_BITS-1:0];
    end else if (task_sel) begin
      key = task_key;
    end
  end

  assign MMU_ADDR = {key, map_page};

  // Map window is supervisor-only; user-state accesses are dropped.
  assign win_wr    = win_hit & ~RnW & ~user_mode;
  assign win_rd    = win_hit & RnW & ~user_mode;
  assign map_wr_oe = nRESET & win_wr & E;

  assign MMU_nWR = ~map_wr_oe;
  assign MMU_nRD = ~(nRESET & (win_rd | (enmmu & ~win_hit)));

  // With translation disabled the physical page is the identity page.
  assign mmu_oe   = map_wr_oe | (nRESET & ~enmmu & ~win_hit);
  assign mmu_out  = map_wr_oe ? DATA : 8'(cpu_page);
  assign MMU_DATA = mmu_oe ? mmu_out : 'z;

  always_comb begin
    reg_rdata = '0;
    case (reg_ofs[2:0])
      REG_CTRL:  reg_rdata = {4'b0000, fault, pend, super_mode, enmmu};
      REG_AKEY:  reg_rdata = 8'(access_key);
      REG_TKEY:  reg_rdata = 8'(task_key);
      REG_RTI:   reg_rdata = RTI_READ_VAL;
      REG_FTASK: reg_rdata = fault_task;
      REG_FPAGE: reg_rdata = fault_page;
      default:   reg_rdata = '0;
    endcase
  end

  assign data_oe  = nRESET & E & RnW & (reg_hit | win_hit);
  assign data_out = win_hit ? (user_mode ? 8'hFF : MMU_DATA) : reg_rdata;
  assign DATA     = data_oe ? data_out : 'z;

  always_ff @(negedge E or negedge nRESET) begin
    if (!nRESET) begin
      enmmu      <= 1'b0;
      access_key <= '0;
      task_key   <= '0;
    end else if (reg_wr) begin
      case (reg_ofs[2:0])
        REG_CTRL: enmmu      <= DATA[0];
        REG_AKEY: access_key <= DATA[TASK_BITS-1:0];
        REG_TKEY: task_key   <= DATA[TASK_BITS-1:0];
        default: ;
      endcase
    end
  end

`ifdef MMU_WPROT_EN
  logic wp_viol;

  assign wp_viol = enmmu & task_sel & ~RnW & ~reg_hit & ~win_hit & MMU_DATA[7];
  assign nWRPROT = ~(nRESET & E & wp_viol);
  assign nFAULT  = ~fault;

  // First fault wins; later faults leave the captured task/page alone.
  always_ff @(negedge E or negedge nRESET) begin
    if (!nRESET) begin
      fault      <= 1'b0;
      fault_task <= '0;
      fault_page <= '0;
    end else if (wp_viol) begin
      if (!fault) begin
        fault      <= 1'b1;
        fault_task <= 8'(task_key);
        fault_page <= 8'(cpu_page);
      end
    end else if (reg_wr && reg_ofs[2:0] == REG_CTRL && DATA[3]) begin
      fault <= 1'b0;
    end
  end
`else
  assign fault      = 1'b0;
  assign fault_task = '0;
  assign fault_page = '0;
  assign nWRPROT    = 1'b1;
  assign nFAULT     = 1'b1;
`endif

endmodule
